// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the scan-phase type used by both axis counters.
package vga_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned H_VISIBLE    = 640;
   localparam int unsigned H_FP         = 16;
   localparam int unsigned H_SYNC       = 96;
   localparam int unsigned H_BP         = 48;
   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

   localparam int unsigned V_VISIBLE    = 480;
   localparam int unsigned V_FP         = 10;
   localparam int unsigned V_SYNC       = 2;
   localparam int unsigned V_BP         = 33;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef enum logic [1:0] {
      VISIBLE = 2'd0,
      FRONT   = 2'd1,
      SYNC    = 2'd2,
      BACK    = 2'd3
   } scan_phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus a registered phase FSM that tracks it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned W         = CNT_W,
   parameter int unsigned P_VISIBLE = H_VISIBLE,
   parameter int unsigned P_FRONT   = H_FP,
   parameter int unsigned P_SYNC    = H_SYNC,
   parameter int unsigned P_BACK    = H_BP
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   output logic [W-1:0] o_count,
   output logic         o_wrap_c,
   output scan_phase_t  o_phase
);

   localparam int unsigned TOTAL = P_VISIBLE + P_FRONT + P_SYNC + P_BACK;

   logic [W-1:0] r_count;
   scan_phase_t  r_phase;

   assign o_wrap_c = (r_count == W'(TOTAL - 1));
   assign o_count  = r_count;
   assign o_phase  = r_phase;

   // Phase changes on the same enable as the count, so it always describes r_count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
         r_phase <= VISIBLE;
      end else if (i_en) begin
         r_count <= o_wrap_c ? '0 : r_count + W'(1);
         case (r_phase)
            VISIBLE: if (r_count == W'(P_VISIBLE - 1))                    r_phase <= FRONT;
            FRONT:   if (r_count == W'(P_VISIBLE + P_FRONT - 1))          r_phase <= SYNC;
            SYNC:    if (r_count == W'(P_VISIBLE + P_FRONT + P_SYNC - 1)) r_phase <= BACK;
            BACK:    if (o_wrap_c)                                         r_phase <= VISIBLE;
            default:                                                       r_phase <= VISIBLE;
         endcase
      end
   end

endmodule

// File: rtl/vga_scan_generator.sv
// Raster scan source: pixel-clock divider, H/V counters, and a one-pixel output stage that
// keeps returned colour aligned with HS/VS/BLANK.
module vga_scan_generator
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 2,   // must be >= 2
   parameter int unsigned P_H_VISIBLE = H_VISIBLE,
   parameter int unsigned P_H_FP      = H_FP,
   parameter int unsigned P_H_SYNC    = H_SYNC,
   parameter int unsigned P_H_BP      = H_BP,
   parameter int unsigned P_V_VISIBLE = V_VISIBLE,
   parameter int unsigned P_V_FP      = V_FP,
   parameter int unsigned P_V_SYNC    = V_SYNC,
   parameter int unsigned P_V_BP      = V_BP
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [7:0]       RGB_R,
   input  logic [7:0]       RGB_G,
   input  logic [7:0]       RGB_B,
   output logic [CNT_W-1:0] DrawX,
   output logic [CNT_W-1:0] DrawY,
   output logic             VGA_CLK,
   output logic             VGA_HS,
   output logic             VGA_VS,
   output logic             VGA_BLANK_N,
   output logic             VGA_SYNC_N,
   output logic [7:0]       VGA_R,
   output logic [7:0]       VGA_G,
   output logic [7:0]       VGA_B,
   output logic             frame_end
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);

   logic [DIV_W-1:0] r_div_cnt;
   logic [DIV_W-1:0] w_div_next;
   logic             w_pix_en;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_visible;
   logic [CNT_W-1:0] w_hc;
   logic [CNT_W-1:0] w_vc;
   scan_phase_t      w_h_phase;
   scan_phase_t      w_v_phase;

   logic             r_vga_clk;
   logic             r_hs;
   logic             r_vs;
   logic             r_blank_n;
   logic [7:0]       r_r;
   logic [7:0]       r_g;
   logic [7:0]       r_b;

   assign w_pix_en   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   assign w_div_next = w_pix_en ? '0 : r_div_cnt + DIV_W'(1);
   assign w_visible  = (w_h_phase == VISIBLE) && (w_v_phase == VISIBLE);

   vga_axis_counter #(
      .W         (CNT_W),
      .P_VISIBLE (P_H_VISIBLE),
      .P_FRONT   (P_H_FP),
      .P_SYNC    (P_H_SYNC),
      .P_BACK    (P_H_BP)
   ) u_h_cnt (
      .i_clk    (Clk),
      .i_rst    (Reset),
      .i_en     (w_pix_en),
      .o_count  (w_hc),
      .o_wrap_c (w_h_wrap),
      .o_phase  (w_h_phase)
   );

   vga_axis_counter #(
      .W         (CNT_W),
      .P_VISIBLE (P_V_VISIBLE),
      .P_FRONT   (P_V_FP),
      .P_SYNC    (P_V_SYNC),
      .P_BACK    (P_V_BP)
   ) u_v_cnt (
      .i_clk    (Clk),
      .i_rst    (Reset),
      .i_en     (w_pix_en & w_h_wrap),
      .o_count  (w_vc),
      .o_wrap_c (w_v_wrap),
      .o_phase  (w_v_phase)
   );

   // Divider and pixel-rate output stage; VGA_CLK rises on the pix_en edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_div_cnt <= '0;
         r_vga_clk <= 1'b0;
         r_hs      <= 1'b1;
         r_vs      <= 1'b1;
         r_blank_n <= 1'b0;
         r_r       <= '0;
         r_g       <= '0;
         r_b       <= '0;
      end else begin
         r_div_cnt <= w_div_next;
         r_vga_clk <= (w_div_next < DIV_W'(CLK_DIV / 2));
         if (w_pix_en) begin
            r_hs      <= (w_h_phase != SYNC);
            r_vs      <= (w_v_phase != SYNC);
            r_blank_n <= w_visible;
            r_r       <= w_visible ? RGB_R : '0;
            r_g       <= w_visible ? RGB_G : '0;
            r_b       <= w_visible ? RGB_B : '0;
         end
      end
   end

   assign DrawX       = w_hc;
   assign DrawY       = w_vc;
   assign VGA_CLK     = r_vga_clk;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_R       = r_r;
   assign VGA_G       = r_g;
   assign VGA_B       = r_b;

   // Pulses during the Clk cycle of the last visible pixel; pix_en is low throughout reset.
   assign frame_end = w_pix_en
                    && (w_hc == CNT_W'(P_H_VISIBLE - 1))
                    && (w_vc == CNT_W'(P_V_VISIBLE - 1));

   logic w_unused;
   assign w_unused = w_v_wrap;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator on a shrunken raster: cycle model plus a pin scoreboard.
module tb_vga_scan_generator;

   localparam int unsigned HV = 16, HFP = 2, HS = 4, HBP = 3;
   localparam int unsigned HT = HV + HFP + HS + HBP;
   localparam int unsigned VV = 6, VFP = 2, VS = 2, VBP = 2;
   localparam int unsigned VT = VV + VFP + VS + VBP;
   localparam int FRAME_CLK = 2 * HT * VT;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       blank_n;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pins_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] RGB_R, RGB_G, RGB_B;
   logic [9:0] DrawX, DrawY;
   logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, frame_end;
   logic [7:0] VGA_R, VGA_G, VGA_B;

   int    errors = 0, checks = 0;
   int    m_div, m_hc, m_vc, cyc, fe_count, fe_last, hs_low, vs_low;
   logic  m_vclk;
   pins_t cur;
   pins_t q[$];
   localparam pins_t RST_PINS = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, r: 8'h0, g: 8'h0, b: 8'h0};

   vga_scan_generator #(
      .CLK_DIV(2),
      .P_H_VISIBLE(HV), .P_H_FP(HFP), .P_H_SYNC(HS), .P_H_BP(HBP),
      .P_V_VISIBLE(VV), .P_V_FP(VFP), .P_V_SYNC(VS), .P_V_BP(VBP)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
      .DrawX(DrawX), .DrawY(DrawY),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .frame_end(frame_end)
   );

   always #5 Clk = ~Clk;

   // Colour mapper stand-in: combinational function of the current scan position.
   assign RGB_R = DrawX[7:0];
   assign RGB_G = DrawY[7:0];
   assign RGB_B = 8'hA5;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic pins_t expect_pins(input int hc, input int vc);
      pins_t p;
      logic  vis;
      vis       = (hc < int'(HV)) && (vc < int'(VV));
      p.hs      = !((hc >= int'(HV + HFP)) && (hc < int'(HV + HFP + HS)));
      p.vs      = !((vc >= int'(VV + VFP)) && (vc < int'(VV + VFP + VS)));
      p.blank_n = vis;
      p.r       = vis ? 8'(hc) : 8'h00;
      p.g       = vis ? 8'(vc) : 8'h00;
      p.b       = vis ? 8'hA5 : 8'h00;
      return p;
   endfunction

   task automatic chk_reset(input string pfx);
      chk({pfx, "_drawx"}, 32'(DrawX), 0);
      chk({pfx, "_drawy"}, 32'(DrawY), 0);
      chk({pfx, "_vga_clk"}, 32'(VGA_CLK), 0);
      chk({pfx, "_hs"}, 32'(VGA_HS), 1);
      chk({pfx, "_vs"}, 32'(VGA_VS), 1);
      chk({pfx, "_blank_n"}, 32'(VGA_BLANK_N), 0);
      chk({pfx, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, 0);
      chk({pfx, "_frame_end"}, 32'(frame_end), 0);
      chk({pfx, "_sync_n"}, 32'(VGA_SYNC_N), 0);
   endtask

   task automatic model_reset();
      m_div = 0; m_hc = 0; m_vc = 0; m_vclk = 1'b0;
      cur = RST_PINS; q.delete(); fe_last = -1;
   endtask

   // Compare the DUT at this falling edge, advance the model across the next rising edge.
   task automatic step();
      if (q.size() > 0) cur = q.pop_front();
      chk("drawx", 32'(DrawX), 32'(m_hc));
      chk("drawy", 32'(DrawY), 32'(m_vc));
      chk("vga_clk", 32'(VGA_CLK), 32'(m_vclk));
      chk("sync_n", 32'(VGA_SYNC_N), 0);
      chk("frame_end", 32'(frame_end),
          32'(m_div == 1 && m_hc == int'(HV) - 1 && m_vc == int'(VV) - 1));
      chk("hs", 32'(VGA_HS), 32'(cur.hs));
      chk("vs", 32'(VGA_VS), 32'(cur.vs));
      chk("blank_n", 32'(VGA_BLANK_N), 32'(cur.blank_n));
      chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, cur.r, cur.g, cur.b});
      if (VGA_HS === 1'b0) hs_low++;
      if (VGA_VS === 1'b0) vs_low++;
      if (frame_end === 1'b1) begin
         fe_count++;
         if (fe_last >= 0) chk("fe_interval", 32'(cyc - fe_last), 32'(FRAME_CLK));
         fe_last = cyc;
      end
      if (m_div == 1) begin
         q.push_back(expect_pins(m_hc, m_vc));
         m_div  = 0;
         m_vclk = 1'b1;
         if (m_hc == int'(HT) - 1) begin
            m_hc = 0;
            m_vc = (m_vc == int'(VT) - 1) ? 0 : m_vc + 1;
         end else begin
            m_hc++;
         end
      end else begin
         m_div  = 1;
         m_vclk = 1'b0;
      end
      cyc++;
      @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b1;
      cyc = 0; fe_count = 0; hs_low = 0; vs_low = 0;
      model_reset();
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk_reset("rst");
      Reset = 1'b0;

      repeat (3 * FRAME_CLK) step();
      chk("fe_count_3frames", 32'(fe_count), 3);
      chk("hs_low_clks", 32'(hs_low), 32'(2 * HS * VT * 3));
      chk("vs_low_clks", 32'(vs_low), 32'(2 * VS * HT * 3));

      repeat ((4 * HT + 10) * 2) step();
      chk("pre_rst_drawx", 32'(DrawX), 10);
      chk("pre_rst_drawy", 32'(DrawY), 4);
      #2 Reset = 1'b1;
      #1 chk_reset("rst_mid");
      @(negedge Clk);
      @(negedge Clk);
      chk_reset("rst_hold");
      Reset = 1'b0;
      model_reset();
      repeat (FRAME_CLK + 20) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
